// File: rtl/sync_filter_edge_if.sv
// sync_filter_edge_if: asynchronous level inputs and filtered level/edge outputs of sync_filter_edge.
interface sync_filter_edge_if #(
  parameter int DATA_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] signal_i;
  logic [DATA_WIDTH-1:0] signal_o;
  logic [DATA_WIDTH-1:0] rise_o;
  logic [DATA_WIDTH-1:0] fall_o;
  modport master (output signal_i, input signal_o, rise_o, fall_o);
  modport slave (input signal_i, output signal_o, rise_o, fall_o);
endinterface

// File: rtl/sync_filter_edge.sv
// sync_filter_edge: per-channel flop-chain synchronizer, stability filter and registered edge pulses.
module sync_filter_edge #(
  parameter int                    DATA_WIDTH    = 1,
  parameter int                    SYNC_STAGES   = 2,
  parameter int                    FILTER_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input logic               sys_clk_i,
  input logic               sys_rst_n_i,
  sync_filter_edge_if.slave bus
);
  localparam int CW = FILTER_CYCLES > 1 ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sig_q, rise_q, fall_q, s, accept;
  assign s = sync_q[SYNC_STAGES-1];
  // a level is accepted once it has differed from the output for FILTER_CYCLES edges in a row
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_ch
    assign accept[i] = (s[i] != sig_q[i]) && (cnt_q[i] == CNT_MAX);
    assign cnt_d[i]  = (s[i] == sig_q[i] || accept[i]) ? '0 : cnt_q[i] + 1'b1;
  end
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      cnt_q  <= '0;
      sig_q  <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.signal_i};
      cnt_q  <= cnt_d;
      sig_q  <= sig_q ^ accept;
      rise_q <= accept & s;
      fall_q <= accept & ~s;
    end
  end
  assign bus.signal_o = sig_q;
  assign bus.rise_o   = rise_q;
  assign bus.fall_o   = fall_q;
endmodule
